// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Sequences every control-flow change into the PC unit. Redirect requests
//   (trap, EX mispredict, fence.i replay) are arbitrated trap > ex > fence.i.
//   Predictor hints are only forwarded when nothing else is happening. After a
//   redirect, flush stays high for a drain window so the PC remains pinned
//   while the pipeline empties. The epoch counter is incremented on every
//   accepted redirect so fetches can be tagged.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   trap_valid / trap_pc              trap or interrupt redirect (highest priority)
//   ex_redir_valid / ex_redir_pc      EX-stage mispredict redirect
//   fencei_valid / fencei_pc          fence.i replay redirect
//   bp_req_valid / bp_req_pc          branch-predictor hint for the current fetch
//   if_ready                          fetch stage accepts the current PC
//   flush / flush_pc                  to PC unit: force next PC = flush_pc
//   bp_valid / bp_pc                  to PC unit: take the predicted target
//   epoch                             current redirect epoch (wraps)
//   busy                              high while a redirect sequence is active
module pc_redirect_ctrl #(
  parameter int DRAIN_CYC  = 2,
  parameter int FENCEI_CYC = 4,
  parameter int EPOCH_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trap_valid,
  input  logic [31:0]        trap_pc,
  input  logic               ex_redir_valid,
  input  logic [31:0]        ex_redir_pc,
  input  logic               fencei_valid,
  input  logic [31:0]        fencei_pc,
  input  logic               bp_req_valid,
  input  logic [31:0]        bp_req_pc,
  input  logic               if_ready,
  output logic               flush,
  output logic [31:0]        flush_pc,
  output logic               bp_valid,
  output logic [31:0]        bp_pc,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CNT_MAX = (DRAIN_CYC > FENCEI_CYC) ? DRAIN_CYC : FENCEI_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] FENCEI_LD = CNT_W'(FENCEI_CYC);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [31:0]        pc_q,    pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               redir_req;

  assign redir_req = trap_valid | ex_redir_valid | fencei_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold default before any branch, so paths
    // that do not assign it cannot infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;

    if (trap_valid) begin
      // A trap wins in every state, including preempting an active drain.
      state_d = REDIR;
      pc_d    = trap_pc;
      cnt_d   = DRAIN_LD;
      epoch_d = epoch_q + EPOCH_W'(1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ex_redir_valid) begin
            state_d = REDIR;
            pc_d    = ex_redir_pc;
            cnt_d   = DRAIN_LD;
            epoch_d = epoch_q + EPOCH_W'(1);
          end else if (fencei_valid) begin
            state_d = REDIR;
            pc_d    = fencei_pc;
            cnt_d   = FENCEI_LD;
            epoch_d = epoch_q + EPOCH_W'(1);
          end
        end
        // ex/fence.i requests seen during REDIR or DRAIN come from squashed
        // instructions and are deliberately ignored.
        REDIR: begin
          state_d = (cnt_q == '0) ? IDLE : DRAIN;
        end
        DRAIN: begin
          // cnt==1 marks the final drain cycle.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // flush and flush_pc depend only on registered state: no input-to-flush path.
  assign flush    = (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign flush_pc = pc_q;
  assign epoch    = epoch_q;

  // Hints pass through only in a quiet IDLE cycle; otherwise they are dropped.
  assign bp_valid = bp_req_valid & if_ready & (state_q == IDLE) & ~redir_req & ~rst;
  assign bp_pc    = bp_req_pc;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl
//   Directed bench for pc_redirect_ctrl. A reference model tracks the number
//   of flush cycles still owed, the current target and the epoch; a compare
//   process checks every DUT output against it on each falling edge. Literal
//   checks in the stimulus pin the model to hand-computed values.
module tb_pc_redirect_ctrl;

  localparam int DRAIN_CYC  = 2;
  localparam int FENCEI_CYC = 4;
  localparam int EPOCH_W    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               trap_valid, ex_redir_valid, fencei_valid, bp_req_valid, if_ready;
  logic [31:0]        trap_pc, ex_redir_pc, fencei_pc, bp_req_pc;
  logic               flush, bp_valid, busy;
  logic [31:0]        flush_pc, bp_pc;
  logic [EPOCH_W-1:0] epoch;

  int n_checks = 0;
  int n_errors = 0;

  pc_redirect_ctrl #(
    .DRAIN_CYC (DRAIN_CYC),
    .FENCEI_CYC(FENCEI_CYC),
    .EPOCH_W   (EPOCH_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trap_valid    (trap_valid),
    .trap_pc       (trap_pc),
    .ex_redir_valid(ex_redir_valid),
    .ex_redir_pc   (ex_redir_pc),
    .fencei_valid  (fencei_valid),
    .fencei_pc     (fencei_pc),
    .bp_req_valid  (bp_req_valid),
    .bp_req_pc     (bp_req_pc),
    .if_ready      (if_ready),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .bp_valid      (bp_valid),
    .bp_pc         (bp_pc),
    .epoch         (epoch),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flush cycles still owed, target, epoch count.
  int          m_rem   = 0;
  logic [31:0] m_pc    = '0;
  int          m_epoch = 0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem   = 0;
      m_pc    = '0;
      m_epoch = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (trap_valid) begin
        m_rem = 1 + DRAIN_CYC;
        m_pc  = trap_pc;
        m_epoch++;
      end else if (m_rem == 0 && ex_redir_valid) begin
        m_rem = 1 + DRAIN_CYC;
        m_pc  = ex_redir_pc;
        m_epoch++;
      end else if (m_rem == 0 && fencei_valid) begin
        m_rem = 1 + FENCEI_CYC;
        m_pc  = fencei_pc;
        m_epoch++;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      automatic bit any_req = trap_valid | ex_redir_valid | fencei_valid;
      automatic bit exp_bp  = bp_req_valid && if_ready && (m_rem == 0) && !any_req && !rst;
      check("model_flush",    32'(flush),    32'(m_rem > 0));
      check("model_busy",     32'(busy),     32'(m_rem > 0));
      check("model_flush_pc", flush_pc,      m_pc);
      check("model_epoch",    32'(epoch),    32'(m_epoch % (1 << EPOCH_W)));
      check("model_bp_valid", 32'(bp_valid), 32'(exp_bp));
      check("model_bp_pc",    bp_pc,         bp_req_pc);
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    trap_valid     = 1'b0;
    ex_redir_valid = 1'b0;
    fencei_valid   = 1'b0;
    bp_req_valid   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_ready = 1'b1;
    trap_pc = '0; ex_redir_pc = '0; fencei_pc = '0; bp_req_pc = '0;
    clear_reqs();

    // 1: reset, no requests
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush",    32'(flush),    32'd0);
    check("rst_bp_valid", 32'(bp_valid), 32'd0);
    check("rst_epoch",    32'(epoch),    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    tick();

    // 2: EX redirect -> 3 flush cycles at 0x100, then idle
    ex_redir_valid = 1'b1; ex_redir_pc = 32'h100;
    tick();
    clear_reqs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ex_flush", 32'(flush), (i < 3) ? 32'd1 : 32'd0);
      if (i < 3) check("ex_flush_pc", flush_pc, 32'h100);
      tick();
    end
    check("ex_epoch", 32'(epoch), 32'd1);

    // 3: trap + ex + bp same cycle -> trap wins, hint dropped
    trap_valid = 1'b1; trap_pc = 32'h80;
    ex_redir_valid = 1'b1; ex_redir_pc = 32'h200;
    bp_req_valid = 1'b1; bp_req_pc = 32'h300;
    @(negedge clk);
    check("prio_bp_valid", 32'(bp_valid), 32'd0);
    tick();
    clear_reqs();
    @(negedge clk);
    check("prio_flush_pc", flush_pc, 32'h80);
    check("prio_epoch",    32'(epoch), 32'd2);
    repeat (3) tick();

    // 4a: fence.i -> 5 flush cycles; ex redirect during DRAIN ignored
    fencei_valid = 1'b1; fencei_pc = 32'h44;
    tick();                                  // REDIR
    clear_reqs();
    tick();                                  // DRAIN
    ex_redir_valid = 1'b1; ex_redir_pc = 32'h200;
    tick();
    clear_reqs();
    @(negedge clk);
    check("fi_ignore_pc",    flush_pc,   32'h44);
    check("fi_ignore_epoch", 32'(epoch), 32'd3);
    tick(); tick();                          // fifth flush cycle
    @(negedge clk);
    check("fi_last_flush", 32'(flush), 32'd1);
    tick();
    @(negedge clk);
    check("fi_done_flush", 32'(flush), 32'd0);
    tick();

    // 4b: trap mid-DRAIN retargets and restarts a 3-cycle window
    fencei_valid = 1'b1; fencei_pc = 32'h44;
    tick();
    clear_reqs();
    tick();                                  // DRAIN
    trap_valid = 1'b1; trap_pc = 32'h90;
    tick();
    clear_reqs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tr_flush", 32'(flush), (i < 3) ? 32'd1 : 32'd0);
      if (i < 3) check("tr_flush_pc", flush_pc, 32'h90);
      tick();
    end
    check("tr_epoch", 32'(epoch), 32'd1);

    // 5: predictor hint gating
    bp_req_valid = 1'b1; bp_req_pc = 32'h300; if_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_valid", 32'(bp_valid), 32'd1);
    check("bp_idle_pc",    bp_pc,         32'h300);
    tick();
    if_ready = 1'b0;
    @(negedge clk);
    check("bp_notready", 32'(bp_valid), 32'd0);
    tick();
    if_ready = 1'b1; bp_req_valid = 1'b0;
    ex_redir_valid = 1'b1; ex_redir_pc = 32'h500;
    tick();
    clear_reqs();
    bp_req_valid = 1'b1;
    @(negedge clk);
    check("bp_busy_busy",  32'(busy),     32'd1);
    check("bp_busy_valid", 32'(bp_valid), 32'd0);
    tick();
    clear_reqs();
    repeat (3) tick();

    // 6: epoch wrap over four back-to-back traps, then reset mid-DRAIN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      trap_valid = 1'b1; trap_pc = 32'h1000 + 32'(k) * 32'h10;
      tick();
      @(negedge clk);
      check("wrap_epoch", 32'(epoch), 32'((k + 1) % 4));
    end
    clear_reqs();
    tick();                                  // DRAIN
    rst = 1'b1;
    @(negedge clk);
    check("rst_drain_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort_flush", 32'(flush),   32'd0);
    check("rst_abort_epoch", 32'(epoch),   32'd0);
    check("rst_abort_pc",    flush_pc,     32'd0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
